// File: rtl/reg_bus_pkg.sv
// rtl/reg_bus_pkg.sv - shared types and constants for the register bus arbiter
package reg_bus_pkg;

  localparam int          REG_AW       = 10;
  localparam int          REG_DW       = 32;
  localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant: a lone request always wins,
// on contention the pointer selects the winner.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/reg_bus_arb.sv
// rtl/reg_bus_arb.sv - two-requester arbiter serialising accesses onto the register file port.
// Optional REG_ARB_TIMEOUT_EN adds a WAIT watchdog returning an error response.
module reg_bus_arb
  import reg_bus_pkg::*;
#(
  parameter int          AW      = REG_AW,
  parameter int          DW      = REG_DW,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          m0_val,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_write,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ready,
  output logic          m0_err,
  input  logic          m1_val,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_write,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ready,
  output logic          m1_err,
  output logic          s_val,
  output logic [AW-1:0] s_addr,
  output logic          s_write,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_ready,
  output logic          gnt_id,
  output logic          busy
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  arb_state_e    state_q, state_d;
  logic          rr_q, rr_d;
  logic          gnt_id_q, gnt_id_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          write_q, write_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          s_val_q, s_val_d;
  logic          busy_q, busy_d;
  logic          m0_ready_q, m0_ready_d;
  logic          m1_ready_q, m1_ready_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic          fin;
  logic [DW-1:0] fin_data;
  logic [1:0]    gnt;
`ifdef REG_ARB_TIMEOUT_EN
  logic [15:0]   tmo_q, tmo_d;
  logic          m0_err_q, m0_err_d;
  logic          m1_err_q, m1_err_d;
  logic          fin_err;
`endif

  rr_arb2 u_rr_arb2 (
    .req ({m1_val, m0_val}),
    .ptr (rr_q),
    .gnt (gnt)
  );

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    gnt_id_d   = gnt_id_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    s_val_d    = 1'b0;
    m0_ready_d = 1'b0;
    m1_ready_d = 1'b0;
    m0_rdata_d = '0;
    m1_rdata_d = '0;
    fin        = 1'b0;
    fin_data   = '0;
`ifdef REG_ARB_TIMEOUT_EN
    tmo_d      = tmo_q;
    m0_err_d   = 1'b0;
    m1_err_d   = 1'b0;
    fin_err    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (|gnt) begin
          gnt_id_d = gnt[1];
          addr_d   = gnt[1] ? m1_addr  : m0_addr;
          write_d  = gnt[1] ? m1_write : m0_write;
          wdata_d  = gnt[1] ? m1_wdata : m0_wdata;
          s_val_d  = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef REG_ARB_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      WAIT: begin
        // A real completion beats a watchdog expiry in the same cycle.
        if (s_ready) begin
          fin      = 1'b1;
          fin_data = s_rdata;
        end
`ifdef REG_ARB_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          fin      = 1'b1;
          fin_data = DW'(ARB_ERR_DATA);
          fin_err  = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
      end
      RESP: begin
        rr_d    = ~gnt_id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (fin) begin
      state_d    = RESP;
      m0_ready_d = ~gnt_id_q;
      m1_ready_d = gnt_id_q;
      m0_rdata_d = gnt_id_q ? '0 : fin_data;
      m1_rdata_d = gnt_id_q ? fin_data : '0;
`ifdef REG_ARB_TIMEOUT_EN
      m0_err_d   = ~gnt_id_q & fin_err;
      m1_err_d   = gnt_id_q & fin_err;
`endif
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      gnt_id_q   <= 1'b0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      s_val_q    <= 1'b0;
      busy_q     <= 1'b0;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
`ifdef REG_ARB_TIMEOUT_EN
      tmo_q      <= '0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      gnt_id_q   <= gnt_id_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      s_val_q    <= s_val_d;
      busy_q     <= busy_d;
      m0_ready_q <= m0_ready_d;
      m1_ready_q <= m1_ready_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
`ifdef REG_ARB_TIMEOUT_EN
      tmo_q      <= tmo_d;
      m0_err_q   <= m0_err_d;
      m1_err_q   <= m1_err_d;
`endif
    end
  end

  assign s_val    = s_val_q;
  assign s_addr   = addr_q;
  assign s_write  = write_q;
  assign s_wdata  = wdata_q;
  assign gnt_id   = gnt_id_q;
  assign busy     = busy_q;
  assign m0_ready = m0_ready_q;
  assign m1_ready = m1_ready_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
`ifdef REG_ARB_TIMEOUT_EN
  assign m0_err   = m0_err_q;
  assign m1_err   = m1_err_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_LAST;
  assign m0_err     = 1'b0;
  assign m1_err     = 1'b0;
`endif

endmodule

// File: tb/tb_reg_bus_arb.sv
// tb/tb_reg_bus_arb.sv - scoreboard bench for reg_bus_arb with a simple echoing register-file model.
module tb_reg_bus_arb;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        m0_val = 1'b0, m0_write = 1'b0, m1_val = 1'b0, m1_write = 1'b0;
  logic [9:0]  m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic [31:0] m0_rdata, m1_rdata, s_wdata;
  logic        m0_ready, m1_ready, m0_err, m1_err;
  logic        s_val, s_write, gnt_id, busy;
  logic [9:0]  s_addr;
  logic [31:0] s_rdata = '0;
  logic        s_ready = 1'b0;

  int          n_vec = 0, n_err = 0, cyc = 0;
  exp_t        exp_q[$];
  logic        exp_gnt_q[$];
  int          rdy_cnt0 = 0, rdy_cnt1 = 0, sval_cnt = 0, sval_cyc = 0;
  logic [9:0]  sval_addr = '0;
  logic [31:0] sval_wdata = '0, rd_base = '0, sl_data = '0;
  logic        prev_sval = 1'b0, slave_en = 1'b1;
  int          late_req = 0, late_done = 0;

  reg_bus_arb #(.AW(10), .DW(32), .TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn),
    .m0_val(m0_val), .m0_addr(m0_addr), .m0_write(m0_write), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_val(m1_val), .m1_addr(m1_addr), .m1_write(m1_write), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
    .s_val(s_val), .s_addr(s_addr), .s_write(s_write), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready), .gnt_id(gnt_id), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_resp(input logic id, input logic [31:0] data, input logic err);
    exp_t e;
    e.id = id; e.data = data; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic wait_ready(input int id, output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if ((id == 0) ? m0_ready : m1_ready) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_vec++; n_err++;
      $display("FAIL wait_ready%0d: no pulse within 40 cycles", id);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_sval"}, {31'b0, s_val}, 0);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_gnt"}, {31'b0, gnt_id}, 0);
    chk({tag, "_saddr"}, {22'b0, s_addr}, 0);
    chk({tag, "_swdata"}, s_wdata, 0);
    chk({tag, "_rdy"}, {30'b0, m1_ready, m0_ready}, 0);
  endtask

  // Monitor: every response pulse is matched against the scoreboard queue.
  initial begin
    exp_t e;
    logic eg;
    forever begin
      @(negedge clk);
      if (m0_ready || m1_ready) begin
        chk("dual_ready", {31'b0, m0_ready & m1_ready}, 0);
        if (m0_ready) rdy_cnt0++;
        if (m1_ready) rdy_cnt1++;
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_ready: m0=%0b m1=%0b with no expected response", m0_ready, m1_ready);
        end else begin
          e = exp_q.pop_front();
          chk("resp_id", {31'b0, m1_ready}, {31'b0, e.id});
          chk("resp_rdata", m1_ready ? m1_rdata : m0_rdata, e.data);
          chk("resp_err", {31'b0, m1_ready ? m1_err : m0_err}, {31'b0, e.err});
        end
      end
      if (!m0_ready) chk("m0_quiet", m0_rdata | {31'b0, m0_err}, 0);
      if (!m1_ready) chk("m1_quiet", m1_rdata | {31'b0, m1_err}, 0);
      if (s_val) begin
        chk("sval_single", {31'b0, prev_sval}, 0);
        if (exp_gnt_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_sval: gnt_id=%0b", gnt_id);
        end else begin
          eg = exp_gnt_q.pop_front();
          chk("gnt_order", {31'b0, gnt_id}, {31'b0, eg});
        end
        sval_cnt++;
        sval_cyc   = cyc;
        sval_addr  = s_addr;
        sval_wdata = s_wdata;
      end
      prev_sval = s_val;
    end
  end

  // Register-file model: write echoes data, read returns rd_base | addr, one cycle after s_val.
  initial begin
    forever begin
      @(negedge clk);
      if (s_val && slave_en) begin
        sl_data = s_write ? s_wdata : (rd_base | {22'b0, s_addr});
        tick();
        s_ready = 1'b1; s_rdata = sl_data;
        tick();
        s_ready = 1'b0; s_rdata = '0;
      end else if (late_req != late_done) begin
        late_done++;
        tick();
        s_ready = 1'b1; s_rdata = 32'hFFFF_FFFF;
        tick();
        s_ready = 1'b0; s_rdata = '0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, at, r1, r2, n, s0, c0, c1;

    // Reset state
    tick(); tick();
    chk_idle_outputs("reset");
    rstn = 1'b1;
    tick();

    // 1: single read
    rd_base = 32'h8000_0A05;
    c1 = rdy_cnt1;
    k = cyc;
    m0_val = 1'b1; m0_addr = 10'h000; m0_write = 1'b0;
    exp_gnt_q.push_back(1'b0);
    push_resp(1'b0, 32'h8000_0A05, 1'b0);
    wait_ready(0, at);
    m0_val = 1'b0;
    chk("t1_latency", at - k, 3);
    chk("t1_sval_cycle", sval_cyc - k, 1);
    tick(); tick();
    chk("t1_m1_silent", rdy_cnt1 - c1, 0);

    // 2: contention from reset, four transactions
    do_reset();
    rd_base = 32'h1234_5600;
    s0 = sval_cnt;
    m0_val = 1'b1; m0_addr = 10'h010; m0_write = 1'b0;
    m1_val = 1'b1; m1_addr = 10'h020; m1_write = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_gnt_q.push_back(1'b0);
      exp_gnt_q.push_back(1'b1);
      push_resp(1'b0, 32'h1234_5610, 1'b0);
      push_resp(1'b1, 32'h1234_5620, 1'b0);
    end
    n = 0;
    for (int i = 0; i < 80 && n < 4; i++) begin
      tick();
      if (m0_ready || m1_ready) n++;
      if (n == 4) begin
        m0_val = 1'b0; m1_val = 1'b0;
      end
    end
    m0_val = 1'b0; m1_val = 1'b0;
    tick(); tick();
    chk("t2_txn_count", n, 4);
    chk("t2_sval_count", sval_cnt - s0, 4);

    // 3: fields latched at grant
    m1_val = 1'b1; m1_addr = 10'h300; m1_write = 1'b1; m1_wdata = 32'h1;
    exp_gnt_q.push_back(1'b1);
    push_resp(1'b1, 32'h0000_0001, 1'b0);
    tick();
    m1_wdata = 32'h0; m1_addr = 10'h000;
    wait_ready(1, at);
    m1_val = 1'b0; m1_write = 1'b0;
    chk("t3_s_wdata", sval_wdata, 32'h1);
    chk("t3_s_addr", {22'b0, sval_addr}, 32'h300);
    tick();

    // 4: back-to-back with val held across ready
    rd_base = 32'h0;
    m0_val = 1'b1; m0_addr = 10'h044;
    exp_gnt_q.push_back(1'b0);
    exp_gnt_q.push_back(1'b0);
    push_resp(1'b0, 32'h44, 1'b0);
    push_resp(1'b0, 32'h44, 1'b0);
    wait_ready(0, r1);
    tick();
    chk("t4_idle_gap_busy", {31'b0, busy}, 0);
    tick();
    chk("t4_regrant_busy", {31'b0, busy}, 1);
    chk("t4_regrant_sval", {31'b0, s_val}, 1);
    wait_ready(0, r2);
    m0_val = 1'b0;
    chk("t4_spacing", r2 - r1, 4);
    tick();

    // 5: reset in WAIT, then a stray s_ready
    slave_en = 1'b0;
    c0 = rdy_cnt0;
    m0_val = 1'b1; m0_addr = 10'h155;
    exp_gnt_q.push_back(1'b0);
    tick(); tick();
    chk("t5_in_wait_busy", {31'b0, busy}, 1);
    rstn = 1'b0; m0_val = 1'b0;
    tick();
    chk_idle_outputs("t5_reset");
    rstn = 1'b1;
    late_req++;
    repeat (6) tick();
    chk("t5_no_pulse", rdy_cnt0 - c0, 0);
    chk("t5_idle_busy", {31'b0, busy}, 0);

    // 6: slave never responds
    k = cyc;
    m0_val = 1'b1; m0_addr = 10'h008;
    exp_gnt_q.push_back(1'b0);
`ifdef REG_ARB_TIMEOUT_EN
    push_resp(1'b0, 32'hDEAD_BEEF, 1'b1);
    wait_ready(0, at);
    m0_val = 1'b0;
    chk("t6_timeout_latency", at - k, 10);
    tick();
    chk("t6_idle_after", {31'b0, busy}, 0);
`else
    c0 = rdy_cnt0;
    tick();
    m0_val = 1'b0;
    repeat (100) tick();
    chk("t6_busy_held", {31'b0, busy}, 1);
    chk("t6_no_pulse", rdy_cnt0 - c0, 0);
    do_reset();
    chk("t6_reset_busy", {31'b0, busy}, 0);
`endif
    slave_en = 1'b1;

    repeat (3) tick();
    chk("resp_queue_drained", exp_q.size(), 0);
    chk("gnt_queue_drained", exp_gnt_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
